aes_selfcheck_driver: RTL and testbench
=======================================

// Module: aes_selfcheck_driver
// PURPOSE
// Synthesizable, emulation-ready self-checking stimulus engine for the AES core.
// Generates NUM_VECTORS pseudo-random key/plaintext pairs and loads each key.
// Encrypts the plaintext, decrypts the resulting ciphertext, and checks that
// the recovered text equals the original. Sits between the top-level start/status
// registers and the AES core request/response ports; no host/file I/O required.
// PARAMETERS
// NUM_VECTORS  4             number of key/text vectors per run (>=1)
// KEY_W        256           key width; legal values 128, 192, 256
// SEED         32'hACE12017  LFSR reset value (must be nonzero)
// TIMEOUT      1024          max cycles spent in any *_REQ/*_WAIT state before abort
// PORTS
// clk          in   1       global clock
// resetH       in   1       asynchronous active-high reset
// start        in   1       1-cycle pulse: begin run (ignored while busy)
// key_valid    out  1       key_data valid to core
// key_ready    in   1       core accepts key when key_valid&&key_ready
// key_data     out  KEY_W   key to core
// req_valid    out  1       block request valid
// req_ready    in   1       core accepts request when req_valid&&req_ready
// req_decrypt  out  1       0=encrypt, 1=decrypt
// req_data     out  128     plaintext (enc) or ciphertext (dec)
// resp_valid   in   1       core result valid
// resp_ready   out  1       driver accepts result; high only in ENC_WAIT/DEC_WAIT
// resp_data    in   128     core result
// busy         out  1       run in progress
// done         out  1       sticky: run finished (normally or by timeout)
// timeout_err  out  1       sticky: run aborted by timeout
// pass_count   out  CW      vectors passed, CW=$clog2(NUM_VECTORS+1)
// fail_count   out  CW      vectors failed
// first_fail   out  CW      index of first failing vector; NUM_VECTORS if none
// vec_valid    out  1       1-cycle pulse in CHECK; vec_* below are valid
// vec_key/vec_text/vec_cipher/vec_plain  out  KEY_W/128/128/128  current vector log
// BEHAVIOUR
// Reset (async, any state): FSM=IDLE, LFSR=SEED, all outputs 0, except
//   first_fail=NUM_VECTORS; all counters 0.
// FSM: IDLE-(start)->GEN->KEY->ENC_REQ->ENC_WAIT->DEC_REQ->DEC_WAIT->CHECK;
//   CHECK->GEN if more vectors, else DONE; DONE-(start)->GEN.
// start in IDLE/DONE: clear done, timeout_err, counts, first_fail; vector idx=0.
//   start in any other state is ignored.
// LFSR: 32-bit Galois, mask 32'h80200003; advances once per GEN cycle only.
// GEN: lasts KEY_W/32+4 cycles. Each cycle shifts the new LFSR value into
//   {key,text}, MSW first: the first KEY_W/32 words form the key, the next 4
//   form the text. LFSR state carries across vectors and runs; only reset
//   reloads SEED.
// KEY: key_valid=1 and key_data stable until the handshake.
// ENC_REQ/DEC_REQ: req_valid=1; data and mode held until req_ready
//   (AXI-style, no retraction).
// ENC_WAIT: the first resp_valid captures vec_cipher.
//   DEC_WAIT: the first resp_valid captures vec_plain.
// CHECK (1 cycle): vec_valid=1. If vec_plain==vec_text, pass_count++;
//   otherwise fail_count++ and, if first_fail==NUM_VECTORS, first_fail=idx.
// Timeout counter: reset on entering KEY/ENC_REQ/ENC_WAIT/DEC_REQ/DEC_WAIT.
//   If it reaches TIMEOUT without the state's handshake: timeout_err=1,
//   deassert all valids, go to DONE. The aborted vector is counted as neither
//   pass nor fail.
// busy=1 in every state except IDLE/DONE. done=1 in DONE.
// A handshake firing in the same cycle as timeout expiry wins (no timeout).
// resp_valid outside the WAIT states is ignored (resp_ready=0).
// Counters never wrap: pass_count+fail_count <= NUM_VECTORS.
// TESTING
// 1 Loopback stub (enc=dec=data^key[127:0]), defaults, start -> done after 4
//   vectors, pass_count=4, fail_count=0, first_fail=4, 4 vec_valid pulses.
// 2 Stub flips bit0 on decrypt only -> fail_count=4, pass_count=0, first_fail=0,
//   vec_plain==vec_text^128'h1.
// 3 req_ready tied 0, TIMEOUT=16 -> timeout_err=1, done=1 within 16+KEY/GEN
//   cycles of entering ENC_REQ; pass=fail=0.
// 4 GEN length: KEY_W=256 -> 12 cycles; KEY_W=128 -> 8 cycles. After reset,
//   the first key word equals the LFSR stepped once from SEED.
// 5 resetH asserted mid-DEC_WAIT -> all outputs 0 on the same edge; second run
//   after release reproduces vector 0 from run 1.
// 6 start pulsed during ENC_WAIT -> ignored, counts unchanged. Random
//   req_ready/resp_valid stalls (0-5 cycles) -> pass_count=NUM_VECTORS.

Source files
------------

// File: rtl/aes_selfcheck_driver_if.sv
// aes_selfcheck_driver_if: key/request/response channels between the self-check driver and the AES core.
interface aes_selfcheck_driver_if #(
   parameter int KEY_W = 256
);
   logic             key_valid;
   logic             key_ready;
   logic [KEY_W-1:0] key_data;
   logic             req_valid;
   logic             req_ready;
   logic             req_decrypt;
   logic [127:0]     req_data;
   logic             resp_valid;
   logic             resp_ready;
   logic [127:0]     resp_data;
   modport master (
      output key_valid, key_data, req_valid, req_decrypt, req_data, resp_ready,
      input  key_ready, req_ready, resp_valid, resp_data
   );
   modport slave (
      input  key_valid, key_data, req_valid, req_decrypt, req_data, resp_ready,
      output key_ready, req_ready, resp_valid, resp_data
   );
endinterface

// File: rtl/aes_selfcheck_driver.sv
// aes_selfcheck_driver: LFSR-driven encrypt/decrypt round-trip checker for the AES core.
module aes_selfcheck_driver #(
   parameter int          NUM_VECTORS = 4,
   parameter int          KEY_W       = 256,
   parameter logic [31:0] SEED        = 32'hACE12017,
   parameter int          TIMEOUT     = 1024,
   localparam int         CW          = $clog2(NUM_VECTORS + 1)
) (
   input  logic                  clk,
   input  logic                  resetH,
   input  logic                  start,
   aes_selfcheck_driver_if.master core,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err,
   output logic [CW-1:0]         pass_count,
   output logic [CW-1:0]         fail_count,
   output logic [CW-1:0]         first_fail,
   output logic                  vec_valid,
   output logic [KEY_W-1:0]      vec_key,
   output logic [127:0]          vec_text,
   output logic [127:0]          vec_cipher,
   output logic [127:0]          vec_plain
);
   localparam int          GL   = KEY_W / 32 + 4;
   localparam int          GW   = $clog2(GL);
   localparam int          TW   = $clog2(TIMEOUT + 1);
   localparam logic [31:0] MASK = 32'h80200003;
   typedef enum logic [3:0] {
      S_IDLE, S_GEN, S_KEY, S_ENC_REQ, S_ENC_WAIT, S_DEC_REQ, S_DEC_WAIT, S_CHECK, S_DONE
   } state_t;
   state_t             r_state, w_nxt;
   logic [GW-1:0]      r_gen;
   logic [TW-1:0]      r_tmo;
   logic [CW-1:0]      r_idx;
   logic [31:0]        r_lfsr, w_lfsr;
   logic [KEY_W+127:0] r_kt;
   logic               w_hs, w_timed, w_tmo, w_start;
   assign w_lfsr           = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? MASK : 32'h0);
   assign {vec_key, vec_text} = r_kt;
   assign w_start          = start && (r_state == S_IDLE || r_state == S_DONE);
   assign core.key_valid   = r_state == S_KEY;
   assign core.key_data    = vec_key;
   assign core.req_valid   = r_state == S_ENC_REQ || r_state == S_DEC_REQ;
   assign core.req_decrypt = r_state == S_DEC_REQ;
   assign core.req_data    = (r_state == S_DEC_REQ) ? vec_cipher : vec_text;
   assign core.resp_ready  = r_state == S_ENC_WAIT || r_state == S_DEC_WAIT;
   assign busy             = !(r_state == S_IDLE || r_state == S_DONE);
   assign done             = r_state == S_DONE;
   assign vec_valid        = r_state == S_CHECK;
   always_comb begin
      w_nxt   = r_state;
      w_hs    = 1'b0;
      w_timed = 1'b0;
      w_tmo   = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: w_nxt = start ? S_GEN : r_state;
         S_GEN:          w_nxt = (r_gen == GW'(GL - 1)) ? S_KEY : S_GEN;
         S_KEY: begin
            w_timed = 1'b1;
            w_hs    = core.key_ready;
            w_nxt   = w_hs ? S_ENC_REQ : S_KEY;
         end
         S_ENC_REQ: begin
            w_timed = 1'b1;
            w_hs    = core.req_ready;
            w_nxt   = w_hs ? S_ENC_WAIT : S_ENC_REQ;
         end
         S_ENC_WAIT: begin
            w_timed = 1'b1;
            w_hs    = core.resp_valid;
            w_nxt   = w_hs ? S_DEC_REQ : S_ENC_WAIT;
         end
         S_DEC_REQ: begin
            w_timed = 1'b1;
            w_hs    = core.req_ready;
            w_nxt   = w_hs ? S_DEC_WAIT : S_DEC_REQ;
         end
         S_DEC_WAIT: begin
            w_timed = 1'b1;
            w_hs    = core.resp_valid;
            w_nxt   = w_hs ? S_CHECK : S_DEC_WAIT;
         end
         S_CHECK: w_nxt = (r_idx == CW'(NUM_VECTORS - 1)) ? S_DONE : S_GEN;
         default: w_nxt = S_IDLE;
      endcase
      // a handshake on the expiry cycle still counts, so only abort without one
      w_tmo = w_timed && !w_hs && (r_tmo == TW'(TIMEOUT - 1));
      if (w_tmo) w_nxt = S_DONE;
   end
   always_ff @(posedge clk or posedge resetH) begin
      if (resetH) begin
         r_state     <= S_IDLE;
         r_gen       <= '0;
         r_tmo       <= '0;
         r_idx       <= '0;
         r_lfsr      <= SEED;
         r_kt        <= '0;
         vec_cipher  <= '0;
         vec_plain   <= '0;
         timeout_err <= 1'b0;
         pass_count  <= '0;
         fail_count  <= '0;
         first_fail  <= CW'(NUM_VECTORS);
      end else begin
         r_state <= w_nxt;
         r_gen   <= (r_state == S_GEN) ? r_gen + 1'b1 : '0;
         r_tmo   <= (w_nxt != r_state) ? '0 : r_tmo + TW'(w_timed);
         if (r_state == S_GEN) begin
            r_lfsr <= w_lfsr;
            r_kt   <= {r_kt[KEY_W+95:0], w_lfsr};
         end
         if (r_state == S_ENC_WAIT && core.resp_valid) vec_cipher <= core.resp_data;
         if (r_state == S_DEC_WAIT && core.resp_valid) vec_plain <= core.resp_data;
         if (w_tmo) timeout_err <= 1'b1;
         if (w_start) begin
            timeout_err <= 1'b0;
            pass_count  <= '0;
            fail_count  <= '0;
            first_fail  <= CW'(NUM_VECTORS);
            r_idx       <= '0;
         end
         if (r_state == S_CHECK) begin
            r_idx <= r_idx + 1'b1;
            if (vec_plain == vec_text) pass_count <= pass_count + 1'b1;
            else begin
               fail_count <= fail_count + 1'b1;
               if (first_fail == CW'(NUM_VECTORS)) first_fail <= r_idx;
            end
         end
      end
   end
endmodule

// File: tb/tb_aes_selfcheck_driver.sv
// tb_aes_selfcheck_driver: randomized loopback-core bench with a word-level LFSR vector model.
module tb_aes_selfcheck_driver;
   localparam logic [31:0] SEED = 32'hACE12017;
   localparam logic [31:0] MASK = 32'h80200003;
   logic clk = 1'b0, resetH = 1'b1, start1 = 1'b0, start2 = 1'b0;
   always #5 clk = ~clk;
   aes_selfcheck_driver_if #(.KEY_W(256)) c1();
   aes_selfcheck_driver_if #(.KEY_W(128)) c2();
   logic         d1_busy, d1_done, d1_tmo, d1_vv;
   logic [2:0]   d1_pass, d1_fail, d1_ff;
   logic [255:0] d1_key;
   logic [127:0] d1_text, d1_cipher, d1_plain;
   logic         d2_busy, d2_done, d2_tmo, d2_vv;
   logic [1:0]   d2_pass, d2_fail, d2_ff;
   logic [127:0] d2_key, d2_text, d2_cipher, d2_plain;
   aes_selfcheck_driver #(.NUM_VECTORS(4), .KEY_W(256), .SEED(SEED), .TIMEOUT(1024)) dut1 (
      .clk(clk), .resetH(resetH), .start(start1), .core(c1),
      .busy(d1_busy), .done(d1_done), .timeout_err(d1_tmo),
      .pass_count(d1_pass), .fail_count(d1_fail), .first_fail(d1_ff),
      .vec_valid(d1_vv), .vec_key(d1_key), .vec_text(d1_text),
      .vec_cipher(d1_cipher), .vec_plain(d1_plain)
   );
   aes_selfcheck_driver #(.NUM_VECTORS(2), .KEY_W(128), .SEED(SEED), .TIMEOUT(16)) dut2 (
      .clk(clk), .resetH(resetH), .start(start2), .core(c2),
      .busy(d2_busy), .done(d2_done), .timeout_err(d2_tmo),
      .pass_count(d2_pass), .fail_count(d2_fail), .first_fail(d2_ff),
      .vec_valid(d2_vv), .vec_key(d2_key), .vec_text(d2_text),
      .vec_cipher(d2_cipher), .vec_plain(d2_plain)
   );
   int n_cmp = 0, n_bad = 0;
   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] step(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? MASK : 32'h0);
   endfunction
   // loopback core: enc = dec = data ^ key[127:0], optional bit0 flip on decrypt
   bit stall = 0, junk = 0, flip = 0, hold = 0, pend = 0, last_dec = 0;
   int kcd = 0, qcd = 0, rcd = 0;
   logic [127:0] res = '0, skey = '0;
   always @(negedge clk) begin
      if (resetH) begin
         c1.key_ready  = 1'b0;
         c1.req_ready  = 1'b0;
         c1.resp_valid = 1'b0;
         pend = 0;
      end else begin
         if (pend && rcd == 0 && !(hold && last_dec)) begin
            c1.resp_valid = 1'b1;
            c1.resp_data  = res;
            if (c1.resp_ready) pend = 0;
         end else begin
            if (pend && rcd > 0) rcd--;
            c1.resp_valid = junk && !c1.resp_ready && $urandom_range(0, 1) == 1;
            c1.resp_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         if (!c1.key_valid) begin
            c1.key_ready = 1'b0;
            kcd = stall ? int'($urandom_range(0, 5)) : 0;
         end else if (kcd == 0) c1.key_ready = 1'b1;
         else begin
            kcd--;
            c1.key_ready = 1'b0;
         end
         if (c1.key_valid && c1.key_ready) skey = c1.key_data[127:0];
         if (!c1.req_valid) begin
            c1.req_ready = 1'b0;
            qcd = stall ? int'($urandom_range(0, 5)) : 0;
         end else if (qcd == 0) c1.req_ready = 1'b1;
         else begin
            qcd--;
            c1.req_ready = 1'b0;
         end
         if (c1.req_valid && c1.req_ready) begin
            pend     = 1;
            last_dec = c1.req_decrypt;
            res      = c1.req_data ^ skey ^ ((c1.req_decrypt && flip) ? 128'h1 : 128'h0);
            rcd      = stall ? int'($urandom_range(0, 5)) : 0;
         end
      end
   end
   // reference: each vector is the next 12 LFSR words, key words first
   logic [31:0]  m_lfsr = SEED;
   logic [383:0] m_kt = '0;
   int pulses = 0;
   always @(negedge clk) begin
      if (!resetH && d1_vv) begin
         for (int i = 0; i < 12; i++) begin
            m_lfsr = step(m_lfsr);
            m_kt   = {m_kt[351:0], m_lfsr};
         end
         check("vec_key", d1_key, m_kt[383:128]);
         check("vec_text", d1_text, m_kt[127:0]);
         check("vec_cipher", d1_cipher, m_kt[127:0] ^ m_kt[255:128]);
         check("vec_plain", d1_plain, m_kt[127:0] ^ {127'b0, flip});
         pulses++;
      end
   end
   task automatic wait_done(input int lim);
      int n = 0;
      while (!d1_done && n < lim) begin
         @(negedge clk);
         n++;
      end
      check("done_reached", d1_done, 1);
   endtask
   task automatic pulse_start1;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      int n;
      c1.key_ready = 1'b0; c1.req_ready = 1'b0; c1.resp_valid = 1'b0; c1.resp_data = '0;
      c2.key_ready = 1'b1; c2.req_ready = 1'b0; c2.resp_valid = 1'b0; c2.resp_data = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", d1_busy, 0);
      check("rst_done", d1_done, 0);
      check("rst_counts", {d1_tmo, d1_pass, d1_fail}, 0);
      check("rst_first_fail", d1_ff, 4);
      check("rst_valids", {d1_vv, c1.key_valid, c1.req_valid, c1.resp_ready}, 0);
      check("rst_vec_key", d1_key, 0);
      resetH = 1'b0;
      @(negedge clk);
      // short-key instance: GEN length, first key word, then stalled request timeout
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n = 0;
      while (!c2.key_valid && n < 100) begin @(negedge clk); n++; end
      check("gen_len_128", n, 8);
      check("key0_128", d2_key[127:96], step(SEED));
      n = 0;
      while (!c2.req_valid && n < 100) begin @(negedge clk); n++; end
      check("enc_req_reached", c2.req_valid, 1);
      n = 0;
      while (!d2_done && n < 100) begin @(negedge clk); n++; end
      check("tmo_len", n >= 16 && n <= 17, 1);
      check("tmo_err", d2_tmo, 1);
      check("tmo_counts", {d2_pass, d2_fail}, 0);
      check("tmo_idle", {d2_busy, c2.req_valid, c2.key_valid}, 0);
      // run 1: clean loopback
      pulses = 0;
      pulse_start1();
      n = 0;
      while (!c1.key_valid && n < 100) begin @(negedge clk); n++; end
      check("gen_len_256", n, 12);
      check("key0_256", d1_key[255:224], step(SEED));
      wait_done(2000);
      check("r1_pass", d1_pass, 4);
      check("r1_fail", d1_fail, 0);
      check("r1_first_fail", d1_ff, 4);
      check("r1_pulses", pulses, 4);
      check("r1_tmo", d1_tmo, 0);
      // run 2: decrypt corrupts bit 0
      flip = 1; pulses = 0;
      pulse_start1();
      wait_done(2000);
      check("r2_pass", d1_pass, 0);
      check("r2_fail", d1_fail, 4);
      check("r2_first_fail", d1_ff, 0);
      // run 3: random stalls, stray resp_valid, start during ENC_WAIT
      flip = 0; stall = 1; junk = 1; pulses = 0;
      pulse_start1();
      n = 0;
      while (!c1.resp_ready && n < 200) begin @(negedge clk); n++; end
      check("enc_wait_reached", c1.resp_ready, 1);
      pulse_start1();
      check("busy_start_ignored", {d1_busy, d1_done}, 2'b10);
      check("counts_start_ignored", {d1_pass, d1_fail}, 0);
      wait_done(5000);
      check("r3_pass", d1_pass, 4);
      check("r3_fail", d1_fail, 0);
      check("r3_pulses", pulses, 4);
      // run 4: reset while waiting for the decrypt result
      stall = 0; junk = 0; hold = 1; last_dec = 0;
      pulse_start1();
      n = 0;
      while (!(c1.resp_ready && last_dec) && n < 200) begin @(negedge clk); n++; end
      check("dec_wait_reached", c1.resp_ready && last_dec, 1);
      resetH = 1'b1;
      #1;
      check("mid_rst_status", {d1_busy, d1_done, d1_tmo, d1_vv, c1.resp_ready}, 0);
      check("mid_rst_counts", {d1_pass, d1_fail, d1_ff}, {3'd0, 3'd0, 3'd4});
      check("mid_rst_vec", {d1_key, d1_cipher}, 0);
      @(negedge clk);
      @(negedge clk);
      hold = 0; last_dec = 0; m_lfsr = SEED; pulses = 0;
      resetH = 1'b0;
      @(negedge clk);
      // run 5: vectors restart from the seed
      pulse_start1();
      n = 0;
      while (!c1.key_valid && n < 100) begin @(negedge clk); n++; end
      check("r5_key0", d1_key[255:224], step(SEED));
      wait_done(2000);
      check("r5_pass", d1_pass, 4);
      check("r5_pulses", pulses, 4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
